bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
- REQ-001: clk5  input  1  5 MHz system clock; all state changes on the rising edge.
- REQ-002: reset_n  input  1  asynchronous, active-low reset.
- REQ-003: start  input  1  one-cycle request to convert bin_in; sampled only in IDLE.
- REQ-004: bin_in  input  14  unsigned binary value, 0..16383.
- REQ-005: point_in  input  4  point-marker pattern, captured with the operand.
- REQ-006: dispVal  output  16  registered 4-digit BCD result; digit 0 in [3:0], digit 3 in [15:12]. Feeds the display interface.
- REQ-007: point  output  4  registered copy of point_in, updated together with dispVal.
- REQ-008: busy  output  1  high while a conversion is in progress.
- REQ-009: done  output  1  one-cycle pulse when dispVal/point have been updated.
- REQ-010: ovf  output  1  registered; set when the last operand exceeded 9999.

Function
- REQ-011: The FSM SHALL have three states:
  - IDLE: start=1 goes to CONV; otherwise it stays in IDLE.
  - CONV: leaves after exactly 14 iterations and goes to DONE.
  - DONE: always returns to IDLE.
- REQ-012: On the edge that samples start=1 in IDLE, the block SHALL:
  - load bin_in into a 14-bit shift register;
  - clear a 20-bit, 5-digit BCD scratch register;
  - latch point_in;
  - clear the 4-bit iteration counter.
- REQ-013: Each CONV cycle SHALL perform one double-dabble iteration:
  - add 3 to every scratch nibble whose value is 5 or greater;
  - shift {scratch, shift register} left by one bit;
  - increment the counter.
- REQ-014: CONV SHALL exit on the edge where the counter equals 13, which is the 14th iteration.
- REQ-015: On entry to DONE, dispVal, point and ovf SHALL update, and done SHALL be high for exactly that one cycle.
  - Latency: done is high in the 15th cycle after the start-sampling edge.
- REQ-016: busy SHALL be high in CONV and DONE, and low in IDLE.
- REQ-017: start while busy=1 SHALL be ignored, with no queuing.
- REQ-017a: start in the same cycle that done=1 SHALL also be ignored; a new start is accepted from the next IDLE cycle.
- REQ-018: dispVal and point SHALL hold their values between conversions. They never show intermediate scratch values.
- REQ-019: ovf SHALL be 1 exactly when the converted operand exceeded 9999.
  - The ovf condition is the fifth scratch digit being non-zero after iteration 14.
- REQ-020: Operands 0..9999 SHALL produce an exact BCD result. No scratch nibble exceeds 9 after any iteration.

Reset
- REQ-021: Assertion of reset_n=0 SHALL immediately set the following, regardless of the clock:
  - state=IDLE;
  - dispVal=16'h0000, point=4'h0;
  - busy=0, done=0, ovf=0;
  - scratch, shift register and counter cleared.
- REQ-022: Reset during CONV or DONE SHALL abort the conversion. No done pulse is produced, and outputs keep their reset values until the next completed conversion.
- REQ-023: The first start is accepted on the first rising edge at which reset_n=1 is sampled.

Configuration
- REQ-024: Macro BCD_SATURATE_EN controls out-of-range handling.
  - Defined: an operand above 9999 SHALL produce dispVal=16'h9999 and ovf=1.
  - Undefined: dispVal SHALL be the low four BCD digits (operand mod 10000) and ovf=1.
  - In-range operands are identical in both builds.

Structure
- REQ-025: Package bin_to_bcd_pkg SHALL hold:
  - the state enum (IDLE, CONV, DONE);
  - BIN_W=14, BCD_DIGITS=4, SCR_DIGITS=5, N_ITER=14, MAX_DEC=9999.
- REQ-026: Sub-module bcd_digit_adj (4-bit in, 4-bit out, add 3 if the input is 5 or greater) SHALL be instantiated once per scratch digit (5 instances). All other logic is in the top module.

Verification
- REQ-027: The bench SHALL cover these directed scenarios:
  - Basic conversion: bin_in=1234, point_in=4'b0100, start -> done in the 15th cycle; dispVal=16'h1234, point=4'b0100, ovf=0.
  - Limits: bin_in=0 -> dispVal=16'h0000. bin_in=9999 -> dispVal=16'h9999, ovf=0.
  - Overflow: bin_in=12345 -> ovf=1. dispVal=16'h9999 with BCD_SATURATE_EN defined, 16'h2345 without. bin_in=16383 -> 16'h9999 or 16'h6383 respectively.
  - Start while busy: start with 42, then start with 7 at cycle 5 -> a single done, dispVal=16'h0042. busy stays high for 15 cycles.
  - Reset mid-conversion: reset_n low at cycle 8 of the conversion -> all outputs 0 immediately and no done pulse. After release, a start with 500 gives dispVal=16'h0500.
  - Exhaustive sweep: 0..9999 back-to-back against a reference model. No start is lost when issued on the first IDLE cycle after done.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and sizing for the sequential binary-to-BCD converter.
// Used by bin_to_bcd_seq and its per-digit adjust cell.
package bin_to_bcd_pkg;

    // Controller states: wait for a request, run the iterations, present the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BIN_W      = 14;     // operand width, 0..16383
    localparam int BCD_DIGITS = 4;      // digits shown on the display
    localparam int SCR_DIGITS = 5;      // scratch digits (one extra to detect > 9999)
    localparam int N_ITER     = 14;     // one double-dabble iteration per operand bit
    localparam int MAX_DEC    = 9999;   // largest value the display can show

    localparam int DISP_W = 4 * BCD_DIGITS;
    localparam int SCR_W  = 4 * SCR_DIGITS;
    localparam int CNT_W  = 4;

    // Counter value during the final iteration
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    // Display pattern used when an out-of-range operand is clamped
    localparam logic [DISP_W-1:0] DISP_SAT = 16'h9999;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction for one scratch digit
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// One iteration per clock; result, point pattern and overflow flag are
// registered on the final iteration and held until the next conversion.
// Build option: define BCD_SATURATE_EN to clamp operands above 9999 to 9999
// on the display; otherwise the low four decimal digits are shown.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
(
    input  logic              clk5,
    input  logic              reset_n,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic [3:0]        point_in,
    output logic [DISP_W-1:0] dispVal,
    output logic [3:0]        point,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    state_t                   state;
    state_t                   state_nxt;

    logic [SCR_W-1:0]         scr;
    logic [SCR_W-1:0]         scr_adj;
    logic [SCR_W-1:0]         scr_nxt;
    logic [BIN_W-1:0]         sh;
    logic [BIN_W-1:0]         sh_nxt;
    logic [SCR_W+BIN_W-1:0]   shifted;
    logic [CNT_W-1:0]         cnt;
    logic [3:0]               pt_lat;

    logic                     accept;
    logic                     last_iter;
    logic                     ovf_nxt;

`ifdef BCD_SATURATE_EN
    // Clamp the displayed value when the operand exceeds the display range
    function automatic logic [DISP_W-1:0] sat_bcd(input logic [DISP_W-1:0] low,
                                                  input logic              over);
        logic [DISP_W-1:0] r;
        r = low;
        if (over) begin
            r = DISP_SAT;
        end
        return r;
    endfunction
`endif

    // One correction cell per scratch digit
    for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr[4*g +: 4]),
            .dout (scr_adj[4*g +: 4])
        );
    end

    // The corrected scratch and the operand shift together as one long register
    assign shifted = {scr_adj, sh} << 1;
    assign scr_nxt = shifted[SCR_W+BIN_W-1:BIN_W];
    assign sh_nxt  = shifted[BIN_W-1:0];

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == CONV) && (cnt == LAST_ITER);

    // The fifth digit is non-zero only for operands above 9999
    assign ovf_nxt = (scr_nxt[SCR_W-1:DISP_W] != 4'd0);

    // Status outputs are decoded straight from the state register
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk5 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a request is only honoured while idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working registers: load on accept, iterate while converting
    always_ff @(posedge clk5 or negedge reset_n) begin
        if (!reset_n) begin
            scr    <= '0;
            sh     <= '0;
            cnt    <= '0;
            pt_lat <= '0;
        end else if (accept) begin
            scr    <= '0;
            sh     <= bin_in;
            cnt    <= '0;
            pt_lat <= point_in;
        end else if (state == CONV) begin
            scr    <= scr_nxt;
            sh     <= sh_nxt;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers: updated only on the final iteration, held otherwise
    always_ff @(posedge clk5 or negedge reset_n) begin
        if (!reset_n) begin
            dispVal <= '0;
            point   <= '0;
            ovf     <= 1'b0;
        end else if (last_iter) begin
`ifdef BCD_SATURATE_EN
            dispVal <= sat_bcd(scr_nxt[DISP_W-1:0], ovf_nxt);
`else
            dispVal <= scr_nxt[DISP_W-1:0];
`endif
            point   <= pt_lat;
            ovf     <= ovf_nxt;
        end
    end

endmodule
